// File: rtl/tl_fc_pkg.sv
// rtl/tl_fc_pkg.sv - shared flow-control types and credit arithmetic helpers
package tl_fc_pkg;

    typedef enum logic [1:0] {
        FC_IDLE   = 2'd0,
        FC_INIT   = 2'd1,
        FC_ACTIVE = 2'd2
    } fc_state_t;

    function automatic logic [2:0] scale_shift(input logic [1:0] scale);
        case (scale)
            2'b10:   return 3'd2;
            2'b11:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Each counter width only accepts the scale encodings that produce it.
    function automatic logic scale_ok(input int f, input logic [1:0] scale);
        case (f)
            8:       return !scale[1];
            10:      return scale == 2'b10;
            12:      return scale == 2'b11;
            default: return 1'b0;
        endcase
    endfunction

    // True when (cl - (cc + req)) mod 2^f does not exceed half the counter range.
    function automatic logic credit_ok(input logic [15:0] cl, input logic [15:0] cc,
                                       input logic [15:0] req, input int f);
        logic [15:0] mask;
        logic [15:0] half;
        logic [15:0] diff;
        mask = 16'((32'd1 << f) - 32'd1);
        half = 16'(32'd1 << (f - 1));
        diff = (cl - cc - req) & mask;
        return diff <= half;
    endfunction

endpackage

// File: rtl/tl_tx_fc_hdr_if.sv
// rtl/tl_tx_fc_hdr_if.sv - DLLP, arbiter and status signals of the header credit gate
interface tl_tx_fc_hdr_if #(parameter int F = 8);
    logic         dll_init;
    logic         fc_valid;
    logic         fc_is_init;
    logic [7:0]   fc_hdr;
    logic [1:0]   fc_hdr_scale;
    logic         tlp_req;
    logic [1:0]   tlp_hdr_creds;
    logic         tlp_grant;
    logic         fc_active;
    logic         hdr_infinite;
    logic [F-1:0] creds_avail_hdr;
    logic         fc_err;

    modport master (
        output dll_init, fc_valid, fc_is_init, fc_hdr, fc_hdr_scale, tlp_req, tlp_hdr_creds,
        input  tlp_grant, fc_active, hdr_infinite, creds_avail_hdr, fc_err
    );

    modport slave (
        input  dll_init, fc_valid, fc_is_init, fc_hdr, fc_hdr_scale, tlp_req, tlp_hdr_creds,
        output tlp_grant, fc_active, hdr_infinite, creds_avail_hdr, fc_err
    );
endinterface

// File: rtl/tl_tx_fc_credit_cmp.sv
// rtl/tl_tx_fc_credit_cmp.sv - modulo-2^F credit limit vs consumed compare
module tl_tx_fc_credit_cmp
    import tl_fc_pkg::*;
#(
    parameter int F = 8
) (
    input  logic [F-1:0] cl,
    input  logic [F-1:0] cc,
    input  logic [F-1:0] req,
    output logic         grant_ok,
    output logic [F-1:0] creds_avail
);
    assign grant_ok    = credit_ok(16'(cl), 16'(cc), 16'(req), F);
    assign creds_avail = cl - cc;
endmodule

// File: rtl/tl_tx_fc_hdr.sv
// rtl/tl_tx_fc_hdr.sv - transmit header credit gate for one FC type
module tl_tx_fc_hdr
    import tl_fc_pkg::*;
#(
    parameter int HDR_FIELD_SIZE = 8
) (
    input  logic           clk,
    input  logic           rst,
    tl_tx_fc_hdr_if.slave  fc
);
    localparam int F = HDR_FIELD_SIZE;

    fc_state_t    state;
    logic [F-1:0] cl;
    logic [F-1:0] cc;
    logic         hdr_inf;
    logic         captured;
    logic         grant_q;
    logic         err_q;

    logic [F-1:0] scaled;
    logic [F-1:0] req_ext;
    logic [F-1:0] creds_diff;
    logic         dllp_ok;
    logic         grant_ok;
    logic         grant_now;

    assign scaled  = F'({8'd0, fc.fc_hdr} << scale_shift(fc.fc_hdr_scale));
    assign req_ext = F'(fc.tlp_hdr_creds);
    assign dllp_ok = scale_ok(F, fc.fc_hdr_scale);

    tl_tx_fc_credit_cmp #(.F(F)) u_cmp (
        .cl          (cl),
        .cc          (cc),
        .req         (req_ext),
        .grant_ok    (grant_ok),
        .creds_avail (creds_diff)
    );

    // A held request is re-evaluated only after its grant pulse has dropped.
    assign grant_now = (state == FC_ACTIVE) && !fc.dll_init && fc.tlp_req && !grant_q
                       && (hdr_inf || grant_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FC_IDLE;
            cl       <= '0;
            cc       <= '0;
            hdr_inf  <= 1'b0;
            captured <= 1'b0;
            grant_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            grant_q <= 1'b0;
            err_q   <= fc.fc_valid && !dllp_ok;
            case (state)
                FC_IDLE: begin
                    if (fc.dll_init) begin
                        state    <= FC_INIT;
                        cl       <= '0;
                        cc       <= '0;
                        hdr_inf  <= 1'b0;
                        captured <= 1'b0;
                    end
                end
                FC_INIT: begin
                    if (!fc.dll_init) begin
                        if (captured) begin
                            state <= FC_ACTIVE;
                        end else begin
                            state <= FC_IDLE;
                            err_q <= 1'b1;
                        end
                    end else if (fc.fc_valid && fc.fc_is_init && dllp_ok && !captured) begin
                        captured <= 1'b1;
                        if (fc.fc_hdr == 8'd0) begin
                            hdr_inf <= 1'b1;
                        end else begin
                            cl <= scaled;
                        end
                    end
                end
                FC_ACTIVE: begin
                    if (fc.dll_init) begin
                        state    <= FC_INIT;
                        cl       <= '0;
                        cc       <= '0;
                        hdr_inf  <= 1'b0;
                        captured <= 1'b0;
                    end else begin
                        if (grant_now) begin
                            grant_q <= 1'b1;
                            if (!hdr_inf) begin
                                cc <= cc + req_ext;
                            end
                        end
                        if (fc.fc_valid && !fc.fc_is_init && dllp_ok) begin
                            if (hdr_inf) begin
                                if (fc.fc_hdr != 8'd0) begin
                                    err_q <= 1'b1;
                                end
                            end else begin
                                cl <= scaled;
                                if (!credit_ok(16'(scaled), 16'(cc), 16'd0, F)) begin
                                    err_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state <= FC_IDLE;
            endcase
        end
    end

    assign fc.tlp_grant       = grant_q;
    assign fc.fc_active       = (state == FC_ACTIVE);
    assign fc.hdr_infinite    = hdr_inf;
    assign fc.creds_avail_hdr = hdr_inf ? '1 : creds_diff;
    assign fc.fc_err          = err_q;
endmodule

// File: tb/tb_tl_tx_fc_hdr.sv
// tb/tb_tl_tx_fc_hdr.sv - directed scoreboard bench for the header credit gate
module tb_tl_tx_fc_hdr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tl_tx_fc_hdr_if #(.F(8))  b8 ();
    tl_tx_fc_hdr_if #(.F(12)) b12 ();

    tl_tx_fc_hdr #(.HDR_FIELD_SIZE(8))  u_dut8  (.clk(clk), .rst(rst), .fc(b8));
    tl_tx_fc_hdr #(.HDR_FIELD_SIZE(12)) u_dut12 (.clk(clk), .rst(rst), .fc(b12));

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        sb_item_t it;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            it = sb_q.pop_front();
            assert (obs === it.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        sb_push(tag, exp);
        sb_check(obs);
    endtask

    task automatic fc_send8(input logic is_init, input logic [7:0] hdr, input logic [1:0] scale);
        b8.fc_valid     = 1'b1;
        b8.fc_is_init   = is_init;
        b8.fc_hdr       = hdr;
        b8.fc_hdr_scale = scale;
        tick();
        b8.fc_valid     = 1'b0;
    endtask

    task automatic init8(input logic [7:0] hdr);
        b8.dll_init = 1'b1;
        tick();
        fc_send8(1'b1, hdr, 2'b00);
        b8.dll_init = 1'b0;
        tick();
    endtask

    task automatic do_req(input logic [1:0] creds, input logic exp_grant);
        b8.tlp_req       = 1'b1;
        b8.tlp_hdr_creds = creds;
        sb_push("grant", 32'(exp_grant));
        tick();
        sb_check(32'(b8.tlp_grant));
        if (exp_grant) begin
            b8.tlp_req = 1'b0;
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        b8.dll_init = 0;  b8.fc_valid = 0;  b8.fc_is_init = 0;  b8.fc_hdr = 0;
        b8.fc_hdr_scale = 0;  b8.tlp_req = 0;  b8.tlp_hdr_creds = 0;
        b12.dll_init = 0; b12.fc_valid = 0; b12.fc_is_init = 0; b12.fc_hdr = 0;
        b12.fc_hdr_scale = 0; b12.tlp_req = 0; b12.tlp_hdr_creds = 0;

        // Reset values
        tick();
        tick();
        chk("rst_grant",  32'(b8.tlp_grant), 0);
        chk("rst_active", 32'(b8.fc_active), 0);
        chk("rst_inf",    32'(b8.hdr_infinite), 0);
        chk("rst_creds",  32'(b8.creds_avail_hdr), 0);
        chk("rst_err",    32'(b8.fc_err), 0);
        chk("rst_creds12", 32'(b12.creds_avail_hdr), 0);
        rst = 1'b0;
        tick();

        // F=12: scale 11 InitFC, then a wrong-scale DLLP is dropped
        b12.dll_init = 1'b1;
        tick();
        b12.fc_valid = 1'b1; b12.fc_is_init = 1'b1; b12.fc_hdr = 8'd8; b12.fc_hdr_scale = 2'b11;
        tick();
        b12.fc_valid = 1'b0; b12.dll_init = 1'b0;
        tick();
        chk("f12_active", 32'(b12.fc_active), 1);
        chk("f12_cl",     32'(b12.creds_avail_hdr), 128);
        b12.fc_valid = 1'b1; b12.fc_is_init = 1'b0; b12.fc_hdr = 8'd9; b12.fc_hdr_scale = 2'b10;
        tick();
        b12.fc_valid = 1'b0;
        chk("f12_bad_scale_err", 32'(b12.fc_err), 1);
        chk("f12_bad_scale_cl",  32'(b12.creds_avail_hdr), 128);
        tick();
        chk("f12_err_pulse", 32'(b12.fc_err), 0);

        // F=8: four grants from CL=4, fifth waits for UpdateFC
        init8(8'd4);
        chk("t1_active", 32'(b8.fc_active), 1);
        chk("t1_creds",  32'(b8.creds_avail_hdr), 4);
        for (int i = 0; i < 4; i++) do_req(2'd1, 1'b1);
        chk("t1_creds_empty", 32'(b8.creds_avail_hdr), 0);
        do_req(2'd1, 1'b0);
        sb_push("t1_grant_upd_cycle", 0);
        fc_send8(1'b0, 8'd6, 2'b00);
        sb_check(32'(b8.tlp_grant));
        chk("t1_creds_upd", 32'(b8.creds_avail_hdr), 2);
        chk("t1_upd_err", 32'(b8.fc_err), 0);
        sb_push("t1_grant_after_upd", 1);
        tick();
        sb_check(32'(b8.tlp_grant));
        b8.tlp_req = 1'b0;
        tick();
        chk("t1_creds_final", 32'(b8.creds_avail_hdr), 1);

        // Same-cycle UpdateFC and request: decision uses the old CL
        init8(8'd3);
        chk("t5_creds_init", 32'(b8.creds_avail_hdr), 3);
        for (int i = 0; i < 3; i++) do_req(2'd1, 1'b1);
        b8.tlp_req = 1'b1;
        b8.tlp_hdr_creds = 2'd1;
        sb_push("t5_grant_same_cycle", 0);
        fc_send8(1'b0, 8'd5, 2'b00);
        sb_check(32'(b8.tlp_grant));
        chk("t5_creds_upd", 32'(b8.creds_avail_hdr), 2);
        sb_push("t5_grant_next", 1);
        tick();
        sb_check(32'(b8.tlp_grant));
        b8.tlp_req = 1'b0;
        tick();
        chk("t5_creds_final", 32'(b8.creds_avail_hdr), 1);

        // Infinite header credits
        init8(8'd0);
        chk("inf_flag",  32'(b8.hdr_infinite), 1);
        chk("inf_creds", 32'(b8.creds_avail_hdr), 8'hFF);
        for (int i = 0; i < 300; i++) do_req(2'(i % 3), 1'b1);
        chk("inf_creds_after", 32'(b8.creds_avail_hdr), 8'hFF);
        fc_send8(1'b0, 8'd5, 2'b00);
        chk("inf_upd_err",   32'(b8.fc_err), 1);
        chk("inf_upd_creds", 32'(b8.creds_avail_hdr), 8'hFF);
        tick();
        chk("inf_err_pulse", 32'(b8.fc_err), 0);

        // Counter wrap: reach CL=0xFE, CC=0xFD
        init8(8'h80);
        for (int i = 0; i < 64; i++) do_req(2'd2, 1'b1);
        chk("wrap_creds_128", 32'(b8.creds_avail_hdr), 0);
        fc_send8(1'b0, 8'hFE, 2'b00);
        chk("wrap_upd_no_err", 32'(b8.fc_err), 0);
        do_req(2'd1, 1'b1);
        for (int i = 0; i < 62; i++) do_req(2'd2, 1'b1);
        chk("wrap_creds_1", 32'(b8.creds_avail_hdr), 1);
        do_req(2'd2, 1'b0);
        sb_push("wrap_grant_upd_cycle", 0);
        fc_send8(1'b0, 8'h02, 2'b00);
        sb_check(32'(b8.tlp_grant));
        chk("wrap_creds_upd", 32'(b8.creds_avail_hdr), 5);
        sb_push("wrap_grant", 1);
        tick();
        sb_check(32'(b8.tlp_grant));
        b8.tlp_req = 1'b0;
        tick();
        chk("wrap_cc_ff", 32'(b8.creds_avail_hdr), 3);

        // UpdateFC beyond half range: error but still loaded
        fc_send8(1'b0, 8'h90, 2'b00);
        chk("sanity_err",   32'(b8.fc_err), 1);
        chk("sanity_creds", 32'(b8.creds_avail_hdr), 8'h91);

        // dll_init rising with a request pending, then falling without InitFC
        b8.tlp_req = 1'b1;
        b8.tlp_hdr_creds = 2'd1;
        b8.dll_init = 1'b1;
        sb_push("reinit_grant", 0);
        tick();
        sb_check(32'(b8.tlp_grant));
        chk("reinit_active", 32'(b8.fc_active), 0);
        chk("reinit_creds",  32'(b8.creds_avail_hdr), 0);
        b8.tlp_req = 1'b0;
        b8.dll_init = 1'b0;
        tick();
        chk("noinit_err",    32'(b8.fc_err), 1);
        chk("noinit_active", 32'(b8.fc_active), 0);
        tick();
        chk("noinit_idle", 32'(b8.fc_active), 0);

        // Reset mid-operation with CC=7 and a request pending
        init8(8'd8);
        for (int i = 0; i < 7; i++) do_req(2'd1, 1'b1);
        chk("rst_mid_creds_pre", 32'(b8.creds_avail_hdr), 1);
        b8.tlp_req = 1'b1;
        rst = 1'b1;
        tick();
        chk("rst_mid_grant",  32'(b8.tlp_grant), 0);
        chk("rst_mid_active", 32'(b8.fc_active), 0);
        chk("rst_mid_creds",  32'(b8.creds_avail_hdr), 0);
        rst = 1'b0;
        b8.tlp_req = 1'b0;
        tick();
        chk("rst_mid_idle", 32'(b8.fc_active), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tl_tx_fc_hdr.md
# tl_tx_fc_hdr

Transmit-side header flow-control credit gate for one FC type (P, NP or Cpl). It stores the header credit limit (CL) advertised by the link partner through InitFC/UpdateFC DLLPs and counts header credits consumed (CC). A TLP is granted only when enough credits remain. It sits between the TX arbiter and the TX DLL interface, and pairs with the receiver-side header credit tracker that produces the partner's UpdateFCs.

## Interface
- HDR_FIELD_SIZE, 8, credit counter width F; legal values are 8, 10 and 12, matching scale 00, 10 and 11.
- clk  in  1  block clock
- rst  in  1  synchronous, active-high reset
- dll_init  in  1  DLL FC initialisation phase; high for the whole InitFC exchange
- fc_valid  in  1  one-cycle strobe: a decoded FC DLLP for this type is present
- fc_is_init  in  1  qualifies fc_valid; 1 = InitFC1/2, 0 = UpdateFC
- fc_hdr  in  8  HdrFC field of the DLLP
- fc_hdr_scale  in  2  HdrScale field of the DLLP
- tlp_req  in  1  arbiter requests transmission of one TLP
- tlp_hdr_creds  in  2  header credits the TLP needs (0–2)
- tlp_grant  out  1  one-cycle pulse; the TLP may go and its credits are consumed
- fc_active  out  1  state is ACTIVE
- hdr_infinite  out  1  partner advertised infinite header credits
- creds_avail_hdr  out  F  (CL − CC) mod 2^F; all ones when infinite
- fc_err  out  1  one-cycle pulse on a protocol error

## Operation
- Scale shift: 00 and 01 give 0, 10 gives 2, 11 gives 4. The received value is (fc_hdr << shift) truncated to F bits.
- Expected scale: 00 or 01 when F=8; exactly 10 when F=10; exactly 11 when F=12. A DLLP with any other scale is dropped and fc_err pulses.

State machine (IDLE, INIT, ACTIVE):
- IDLE: when dll_init=1, go to INIT and clear CC, CL, hdr_infinite and the init-captured flag.
- INIT, on fc_valid & fc_is_init:
  - fc_hdr=0: set hdr_infinite=1.
  - Otherwise: CL ← scaled value.
  - Either way, set init-captured. The first InitFC wins; later InitFCs in INIT are ignored.
- INIT, on dll_init falling:
  - Init captured: go to ACTIVE.
  - Not captured: go to IDLE and pulse fc_err.
- ACTIVE:
  - UpdateFC with hdr_infinite=0: CL ← scaled value.
  - UpdateFC with hdr_infinite=1: ignored. If fc_hdr≠0, fc_err pulses.
  - InitFC: ignored.
  - dll_init=1: go to INIT with the same clearing as IDLE.
- Update sanity check: if (new CL − CC) mod 2^F > 2^(F−1), fc_err pulses but CL is still loaded.

Grant condition, evaluated only in ACTIVE:
- Always granted when hdr_infinite=1.
- Otherwise granted when (CL − (CC + tlp_hdr_creds)) mod 2^F ≤ 2^(F−1).

On grant: CC ← (CC + tlp_hdr_creds) mod 2^F, unless hdr_infinite=1. CC wraps naturally.

Handshake:
- The arbiter holds tlp_req and tlp_hdr_creds stable until it sees tlp_grant.
- The arbiter drops tlp_req in the cycle after the grant, or presents a new request.
- No grant is issued while outside ACTIVE, and none in the first ACTIVE cycle.

## Timing
- Reset values: state=IDLE, CL=0, CC=0, and tlp_grant, fc_active, hdr_infinite and fc_err all 0. creds_avail_hdr=0.
- tlp_grant is registered. It asserts the cycle after a tlp_req that meets the condition against the registered CL/CC.
- After a grant, CC updates in the same edge, so a held request re-evaluates against the new CC on the next cycle. Back-to-back grants are possible every other cycle for a continuously held request. A new request can be granted the cycle after the previous grant deasserts.
- Simultaneous UpdateFC and grant in one cycle: both take effect at that edge. The grant decision uses the pre-update CL.
- UpdateFC effect: CL is visible on creds_avail_hdr one cycle after fc_valid, and in the grant decision from then on.
- dll_init rising in ACTIVE with a request pending: no grant at or after that edge. CC is cleared.
- rst mid-operation: all state returns to reset values at the next edge, regardless of other inputs.
- fc_err is registered and pulses one cycle after the offending event.

## Structure
- Shared tl_fc_pkg holds:
  - state encoding;
  - the scale-to-shift function;
  - the expected-scale-per-width function;
  - the modulo credit-check function (CL, CC, req, F), so the data-credit gate can reuse it.
- One natural sub-module, tl_tx_fc_credit_cmp: a combinational modulo-2^F compare returning grant_ok and creds_avail. It is parameterised on F and reused by the data-credit gate.

## Test plan
- F=8: dll_init pulse with InitFC hdr=4, then dll_init low → ACTIVE, creds_avail=4. Four 1-credit requests are granted. The fifth gets no grant; an UpdateFC hdr=6 then grants it one cycle later.
- F=8, InitFC hdr=0 → hdr_infinite=1 and creds_avail=0xFF. 300 grants go through. An UpdateFC hdr=5 is ignored and pulses fc_err.
- F=12, InitFC hdr=8 with scale 11 → CL=128. A DLLP with scale 10 is dropped and pulses fc_err.
- F=8, wrap: CL=0xFE, CC=0xFD. A 2-credit request is denied. An UpdateFC hdr=0x02 (CL=0x102 mod 256) grants it and CC becomes 0xFF.
- UpdateFC and grant in the same cycle: CL=CC=3 with a pending request and an update to 5 → no grant that cycle, grant the next cycle.
- dll_init low without InitFC → IDLE with fc_err. rst asserted in ACTIVE with CC=7 → CC=0, state IDLE, tlp_grant=0.
